// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - fault codes, TLB entry record and page match function; TLB_ASID_EN adds the ASID field and term
package mmu_pkg;

    localparam int MMU_PAGE_W = 20;
    localparam int MMU_ASID_W = 6;

    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_MISS = 2'b01;
    localparam logic [1:0] FAULT_WP   = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic                  ro;
        logic [MMU_PAGE_W-1:0] vpage;
        logic [MMU_PAGE_W-1:0] ppage;
`ifdef TLB_ASID_EN
        logic [MMU_ASID_W-1:0] asid;
`endif
    } tlb_entry_t;

    function automatic logic page_match(
        input logic                  valid,
        input logic [MMU_PAGE_W-1:0] entry_vpage,
        input logic [MMU_PAGE_W-1:0] lookup_vpage
`ifdef TLB_ASID_EN
        ,
        input logic [MMU_ASID_W-1:0] entry_asid,
        input logic [MMU_ASID_W-1:0] lookup_asid
`endif
    );
`ifdef TLB_ASID_EN
        return valid && (entry_vpage == lookup_vpage) && (entry_asid == lookup_asid);
`else
        return valid && (entry_vpage == lookup_vpage);
`endif
    endfunction

endpackage

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - single-entry TLB comparator producing the hit bit; TLB_ASID_EN adds the ASID compare
module tlb_match
    import mmu_pkg::*;
(
    input  logic                  valid,
    input  logic [MMU_PAGE_W-1:0] entry_vpage,
    input  logic [MMU_PAGE_W-1:0] lookup_vpage,
`ifdef TLB_ASID_EN
    input  logic [MMU_ASID_W-1:0] entry_asid,
    input  logic [MMU_ASID_W-1:0] lookup_asid,
`endif
    output logic                  hit
);

    assign hit = page_match(valid, entry_vpage, lookup_vpage
`ifdef TLB_ASID_EN
                            , entry_asid, lookup_asid
`endif
                           );

endmodule

// File: rtl/tlb_mmu.sv
// rtl/tlb_mmu.sv - fully associative TLB MMU with ro faults, round-robin refill and flush; TLB_ASID_EN enables ASID tagging
module tlb_mmu
    import mmu_pkg::*;
#(
    parameter int PAGE_NUM_WIDTH = MMU_PAGE_W,
    parameter int ENTRIES        = 8,
    parameter int ASID_WIDTH     = MMU_ASID_W
) (
    input  logic                      clk,
    input  logic                      clrn,
    input  logic                      stall,
    input  logic                      mmu_en,
    input  logic                      mmu_update,
    input  logic [31:0]               vaddr_in,
    input  logic                      wr_in,
    input  logic                      tlb_we,
    input  logic [PAGE_NUM_WIDTH-1:0] tlb_vpage,
    input  logic [PAGE_NUM_WIDTH-1:0] tlb_ppage,
    input  logic                      tlb_ro,
    input  logic                      tlb_flush,
`ifdef TLB_ASID_EN
    input  logic [ASID_WIDTH-1:0]     asid_in,
`endif
    output logic [31:0]               paddr_o,
    output logic [1:0]                fault_o,
    output logic                      mmu_error_o,
    output logic                      full_o
);

    localparam int OFF_W = 32 - PAGE_NUM_WIDTH;
    localparam int IDX_W = $clog2(ENTRIES);

    // The entry record in mmu_pkg fixes the page and ASID widths.
    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 ||
        PAGE_NUM_WIDTH != MMU_PAGE_W || ASID_WIDTH != MMU_ASID_W) begin : g_bad_cfg
        $error("tlb_mmu: unsupported parameter combination");
    end

    logic [ENTRIES-1:0]        valid_q;
    logic [ENTRIES-1:0]        ro_q;
    logic [PAGE_NUM_WIDTH-1:0] vpage_q [ENTRIES];
    logic [PAGE_NUM_WIDTH-1:0] ppage_q [ENTRIES];
    logic                      en_reg;
    logic [IDX_W-1:0]          rr_ptr;
    tlb_entry_t                entry   [ENTRIES];

`ifdef TLB_ASID_EN
    logic [ASID_WIDTH-1:0]     asid_q  [ENTRIES];
    logic [ASID_WIDTH-1:0]     asid_reg;
    logic [ASID_WIDTH-1:0]     eff_asid;

    assign eff_asid = mmu_update ? asid_in : asid_reg;
`endif

    logic                      eff_en;
    logic [PAGE_NUM_WIDTH-1:0] tag;
    logic [ENTRIES-1:0]        hit_vec;
    logic [IDX_W-1:0]          hit_idx;
    tlb_entry_t                hit_entry;
    logic                      wmatch_any;
    logic [IDX_W-1:0]          wmatch_idx;
    logic [IDX_W-1:0]          inv_idx;
    logic [IDX_W-1:0]          wr_idx;

    assign eff_en = mmu_update ? mmu_en : en_reg;
    assign tag    = vaddr_in[31 -: PAGE_NUM_WIDTH];
    assign full_o = &valid_q;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            entry[i].valid = valid_q[i];
            entry[i].ro    = ro_q[i];
            entry[i].vpage = vpage_q[i];
            entry[i].ppage = ppage_q[i];
`ifdef TLB_ASID_EN
            entry[i].asid  = asid_q[i];
`endif
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_match
        tlb_match u_match (
            .valid        (entry[i].valid),
            .entry_vpage  (entry[i].vpage),
            .lookup_vpage (tag),
`ifdef TLB_ASID_EN
            .entry_asid   (entry[i].asid),
            .lookup_asid  (eff_asid),
`endif
            .hit          (hit_vec[i])
        );
    end

    // The write rule never creates duplicate mappings, so hit_vec is at most one-hot.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (hit_vec[i]) hit_idx = IDX_W'(i);
        end
    end

    assign hit_entry = entry[hit_idx];

    always_comb begin
        paddr_o = vaddr_in;
        fault_o = FAULT_NONE;
        if (eff_en) begin
            if (|hit_vec) begin
                paddr_o = {hit_entry.ppage, vaddr_in[OFF_W-1:0]};
                if (hit_entry.ro && wr_in) fault_o = FAULT_WP;
            end else begin
                fault_o = FAULT_MISS;
            end
        end
    end

    assign mmu_error_o = |fault_o;

    always_comb begin
        wmatch_any = 1'b0;
        wmatch_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (page_match(entry[i].valid, entry[i].vpage, tlb_vpage
`ifdef TLB_ASID_EN
                           , entry[i].asid, eff_asid
`endif
                          )) begin
                wmatch_any = 1'b1;
                wmatch_idx = IDX_W'(i);
            end
        end
    end

    // Descending scan so the lowest-index invalid entry wins.
    always_comb begin
        inv_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) inv_idx = IDX_W'(i);
        end
    end

    assign wr_idx = wmatch_any ? wmatch_idx : (full_o ? rr_ptr : inv_idx);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q  <= '0;
            ro_q     <= '0;
            en_reg   <= 1'b0;
            rr_ptr   <= '0;
`ifdef TLB_ASID_EN
            asid_reg <= '0;
`endif
        end else if (!stall) begin
            if (mmu_update) begin
                en_reg   <= mmu_en;
`ifdef TLB_ASID_EN
                asid_reg <= asid_in;
`endif
            end
            if (tlb_flush) begin
                valid_q <= '0;
                rr_ptr  <= '0;
            end else if (tlb_we) begin
                valid_q[wr_idx] <= 1'b1;
                ro_q[wr_idx]    <= tlb_ro;
                if (!wmatch_any && full_o) rr_ptr <= rr_ptr + IDX_W'(1);
            end
        end
    end

    // Mapping payload carries no reset; valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (!stall && tlb_we && !tlb_flush) begin
            vpage_q[wr_idx] <= tlb_vpage;
            ppage_q[wr_idx] <= tlb_ppage;
`ifdef TLB_ASID_EN
            asid_q[wr_idx]  <= eff_asid;
`endif
        end
    end

endmodule

// File: tb/tb_tlb_mmu.sv
// tb/tb_tlb_mmu.sv - self-checking scoreboard bench for tlb_mmu
module tb_tlb_mmu;

    logic        clk = 1'b0;
    logic        clrn, stall, mmu_en, mmu_update, wr_in, tlb_we, tlb_ro, tlb_flush;
    logic [31:0] vaddr_in;
    logic [19:0] tlb_vpage, tlb_ppage;
`ifdef TLB_ASID_EN
    logic [5:0]  asid_in;
`endif
    logic [31:0] paddr_o;
    logic [1:0]  fault_o;
    logic        mmu_error_o, full_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlb_mmu #(.PAGE_NUM_WIDTH(20), .ENTRIES(8), .ASID_WIDTH(6)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .stall       (stall),
        .mmu_en      (mmu_en),
        .mmu_update  (mmu_update),
        .vaddr_in    (vaddr_in),
        .wr_in       (wr_in),
        .tlb_we      (tlb_we),
        .tlb_vpage   (tlb_vpage),
        .tlb_ppage   (tlb_ppage),
        .tlb_ro      (tlb_ro),
        .tlb_flush   (tlb_flush),
`ifdef TLB_ASID_EN
        .asid_in     (asid_in),
`endif
        .paddr_o     (paddr_o),
        .fault_o     (fault_o),
        .mmu_error_o (mmu_error_o),
        .full_o      (full_o)
    );

    typedef struct {
        string       name;
        logic [31:0] paddr;
        logic [1:0]  fault;
        logic        err;
        logic        full;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];

    // Reference model of the TLB contents
    logic        m_valid [8];
    logic        m_ro    [8];
    logic [19:0] m_vp    [8];
    logic [19:0] m_pp    [8];
    int          m_rr;
    logic        m_en;

    function automatic logic model_full();
        logic f;
        f = 1'b1;
        for (int i = 0; i < 8; i++) f = f & m_valid[i];
        return f;
    endfunction

    function automatic logic model_present(input logic [19:0] vp);
        for (int i = 0; i < 8; i++) if (m_valid[i] && m_vp[i] == vp) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_widx(input logic [19:0] vp);
        for (int i = 0; i < 8; i++) if (m_valid[i] && m_vp[i] == vp) return i;
        for (int i = 0; i < 8; i++) if (!m_valid[i]) return i;
        return m_rr;
    endfunction

    function automatic void model_lookup(input logic [31:0] va, input logic wr,
                                         output logic [31:0] p, output logic [1:0] f);
        logic en;
        en = mmu_update ? mmu_en : m_en;
        p  = va;
        f  = 2'b00;
        if (en) begin
            f = 2'b01;
            for (int i = 0; i < 8; i++) begin
                if (m_valid[i] && m_vp[i] == va[31:12]) begin
                    p = {m_pp[i], va[11:0]};
                    f = (m_ro[i] && wr) ? 2'b10 : 2'b00;
                end
            end
        end
    endfunction

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[i] <= 1'b0;
                m_ro[i]    <= 1'b0;
            end
            m_rr <= 0;
            m_en <= 1'b0;
        end else if (!stall) begin
            if (mmu_update) m_en <= mmu_en;
            if (tlb_flush) begin
                for (int i = 0; i < 8; i++) m_valid[i] <= 1'b0;
                m_rr <= 0;
            end else if (tlb_we) begin
                m_valid[model_widx(tlb_vpage)] <= 1'b1;
                m_ro[model_widx(tlb_vpage)]    <= tlb_ro;
                m_vp[model_widx(tlb_vpage)]    <= tlb_vpage;
                m_pp[model_widx(tlb_vpage)]    <= tlb_ppage;
                if (!model_present(tlb_vpage) && model_full()) m_rr <= (m_rr + 1) % 8;
            end
        end
    end

    task automatic probe_exp(input string name, input logic [31:0] va, input logic wr,
                             input logic [31:0] p, input logic [1:0] f, input logic fl);
        vaddr_in = va;
        wr_in    = wr;
        exp_q.push_back('{name, p, f, (f != 2'b00), fl});
        #1;
        obs_q.push_back('{name, paddr_o, fault_o, mmu_error_o, full_o});
    endtask

    task automatic probe(input string name, input logic [31:0] va, input logic wr);
        logic [31:0] p;
        logic [1:0]  f;
        model_lookup(va, wr, p, f);
        probe_exp(name, va, wr, p, f, model_full());
    endtask

    task automatic test_reset();
        res_t e, o;
        repeat (2) @(negedge clk);
        probe_exp("reset_passthru", 32'h1234_5678, 1'b0, 32'h1234_5678, 2'b00, 1'b0);
        probe_exp("reset_store", 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0);
        @(negedge clk);
        clrn = 1'b1;
        probe_exp("kernel_passthru", 32'h0040_0ABC, 1'b0, 32'h0040_0ABC, 2'b00, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.paddr !== e.paddr || o.fault !== e.fault || o.err !== e.err || o.full !== e.full) begin
                errors++;
                $display("FAIL %s: got paddr=%h fault=%b err=%b full=%b want paddr=%h fault=%b err=%b full=%b",
                         e.name, o.paddr, o.fault, o.err, o.full, e.paddr, e.fault, e.err, e.full);
            end
        end
    endtask

    task automatic test_translate();
        res_t e, o;
        @(negedge clk);
        mmu_update = 1'b1;
        mmu_en     = 1'b1;
        probe_exp("eret_bypass_miss", 32'h0040_0ABC, 1'b0, 32'h0040_0ABC, 2'b01, 1'b0);
        @(negedge clk);
        mmu_update = 1'b0;
        tlb_we     = 1'b1;
        tlb_vpage  = 20'h00400;
        tlb_ppage  = 20'h80010;
        tlb_ro     = 1'b0;
        probe_exp("write_cycle_miss", 32'h0040_0ABC, 1'b0, 32'h0040_0ABC, 2'b01, 1'b0);
        @(negedge clk);
        tlb_we = 1'b0;
        probe_exp("load_hit", 32'h0040_0ABC, 1'b0, 32'h8001_0ABC, 2'b00, 1'b0);
        probe_exp("other_page_miss", 32'h0040_2ABC, 1'b0, 32'h0040_2ABC, 2'b01, 1'b0);
        @(negedge clk);
        mmu_update = 1'b1;
        mmu_en     = 1'b0;
        probe_exp("eret_kernel_bypass", 32'h0040_0ABC, 1'b0, 32'h0040_0ABC, 2'b00, 1'b0);
        @(negedge clk);
        mmu_en = 1'b1;
        @(negedge clk);
        mmu_update = 1'b0;
        probe_exp("user_again_hit", 32'h0040_0123, 1'b1, 32'h8001_0123, 2'b00, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.paddr !== e.paddr || o.fault !== e.fault || o.err !== e.err || o.full !== e.full) begin
                errors++;
                $display("FAIL %s: got paddr=%h fault=%b err=%b full=%b want paddr=%h fault=%b err=%b full=%b",
                         e.name, o.paddr, o.fault, o.err, o.full, e.paddr, e.fault, e.err, e.full);
            end
        end
    endtask

    task automatic test_write_protect();
        res_t e, o;
        @(negedge clk);
        tlb_we    = 1'b1;
        tlb_vpage = 20'h00401;
        tlb_ppage = 20'h80011;
        tlb_ro    = 1'b1;
        @(negedge clk);
        tlb_we = 1'b0;
        tlb_ro = 1'b0;
        probe_exp("wp_store", 32'h0040_1000, 1'b1, 32'h8001_1000, 2'b10, 1'b0);
        probe_exp("wp_load", 32'h0040_1000, 1'b0, 32'h8001_1000, 2'b00, 1'b0);
        probe_exp("rw_store", 32'h0040_0ABC, 1'b1, 32'h8001_0ABC, 2'b00, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.paddr !== e.paddr || o.fault !== e.fault || o.err !== e.err || o.full !== e.full) begin
                errors++;
                $display("FAIL %s: got paddr=%h fault=%b err=%b full=%b want paddr=%h fault=%b err=%b full=%b",
                         e.name, o.paddr, o.fault, o.err, o.full, e.paddr, e.fault, e.err, e.full);
            end
        end
    endtask

    task automatic test_fill_replace();
        res_t e, o;
        @(negedge clk);
        tlb_flush = 1'b1;
        @(negedge clk);
        tlb_flush = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tlb_we    = 1'b1;
            tlb_vpage = 20'h10000 + 20'(i);
            tlb_ppage = 20'h20000 + 20'(i);
            @(negedge clk);
            tlb_we = 1'b0;
            probe("fill_step", {20'h10000 + 20'(i), 12'h0}, 1'b0);
            if (i == 6) probe_exp("not_full_after_7", 32'h1000_6004, 1'b0, 32'h2000_6004, 2'b00, 1'b0);
            if (i == 7) probe_exp("full_after_8", 32'h1000_7004, 1'b0, 32'h2000_7004, 2'b00, 1'b1);
            @(negedge clk);
        end
        probe_exp("evicted_entry0", 32'h1000_0000, 1'b0, 32'h1000_0000, 2'b01, 1'b1);
        probe_exp("ninth_hit", 32'h1000_8123, 1'b0, 32'h2000_8123, 2'b00, 1'b1);
        probe_exp("entry1_kept", 32'h1000_1000, 1'b0, 32'h2000_1000, 2'b00, 1'b1);
        @(negedge clk);
        tlb_we    = 1'b1;
        tlb_vpage = 20'h10003;
        tlb_ppage = 20'h3ABCD;
        @(negedge clk);
        tlb_vpage = 20'h1000A;
        tlb_ppage = 20'h2000A;
        probe_exp("rewrite_hit", 32'h1000_3456, 1'b0, 32'h3ABC_D456, 2'b00, 1'b1);
        @(negedge clk);
        tlb_we = 1'b0;
        probe_exp("rr_evicts_entry1", 32'h1000_1000, 1'b0, 32'h1000_1000, 2'b01, 1'b1);
        probe_exp("rewrite_kept", 32'h1000_3456, 1'b0, 32'h3ABC_D456, 2'b00, 1'b1);
        probe_exp("entry2_kept", 32'h1000_2000, 1'b0, 32'h2000_2000, 2'b00, 1'b1);
        probe_exp("new_page_hit", 32'h1000_AFFF, 1'b0, 32'h2000_AFFF, 2'b00, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.paddr !== e.paddr || o.fault !== e.fault || o.err !== e.err || o.full !== e.full) begin
                errors++;
                $display("FAIL %s: got paddr=%h fault=%b err=%b full=%b want paddr=%h fault=%b err=%b full=%b",
                         e.name, o.paddr, o.fault, o.err, o.full, e.paddr, e.fault, e.err, e.full);
            end
        end
    endtask

    task automatic test_flush_stall();
        res_t e, o;
        @(negedge clk);
        tlb_flush = 1'b1;
        tlb_we    = 1'b1;
        tlb_vpage = 20'h55555;
        tlb_ppage = 20'h66666;
        probe_exp("flush_cycle_old", 32'h1000_8000, 1'b0, 32'h2000_8000, 2'b00, 1'b1);
        @(negedge clk);
        tlb_flush = 1'b0;
        tlb_we    = 1'b0;
        probe_exp("flushed_miss", 32'h1000_8000, 1'b0, 32'h1000_8000, 2'b01, 1'b0);
        probe_exp("flush_drops_we", 32'h5555_5000, 1'b0, 32'h5555_5000, 2'b01, 1'b0);
        @(negedge clk);
        tlb_we    = 1'b1;
        tlb_vpage = 20'h00700;
        tlb_ppage = 20'h00777;
        @(negedge clk);
        stall      = 1'b1;
        tlb_flush  = 1'b1;
        tlb_vpage  = 20'h00800;
        tlb_ppage  = 20'h00888;
        mmu_update = 1'b1;
        mmu_en     = 1'b0;
        probe_exp("stall_bypass_kernel", 32'h0070_0010, 1'b0, 32'h0070_0010, 2'b00, 1'b0);
        @(negedge clk);
        stall      = 1'b0;
        tlb_flush  = 1'b0;
        tlb_we     = 1'b0;
        mmu_update = 1'b0;
        mmu_en     = 1'b1;
        probe_exp("stall_kept", 32'h0070_0010, 1'b0, 32'h0077_7010, 2'b00, 1'b0);
        probe_exp("stall_no_write", 32'h0080_0010, 1'b0, 32'h0080_0010, 2'b01, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.paddr !== e.paddr || o.fault !== e.fault || o.err !== e.err || o.full !== e.full) begin
                errors++;
                $display("FAIL %s: got paddr=%h fault=%b err=%b full=%b want paddr=%h fault=%b err=%b full=%b",
                         e.name, o.paddr, o.fault, o.err, o.full, e.paddr, e.fault, e.err, e.full);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t e, o;
        @(negedge clk);
        tlb_flush = 1'b1;
        @(negedge clk);
        tlb_flush = 1'b0;
        for (int n = 0; n < 48; n++) begin
            @(negedge clk);
            tlb_we    = 1'($urandom_range(0, 1));
            tlb_vpage = 20'h00300 + 20'($urandom_range(0, 11));
            tlb_ppage = 20'($urandom);
            tlb_ro    = 1'($urandom_range(0, 1));
            probe("b2b", {20'h00300 + 20'($urandom_range(0, 11)), 12'($urandom)}, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        tlb_we = 1'b0;
        tlb_ro = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.paddr !== e.paddr || o.fault !== e.fault || o.err !== e.err || o.full !== e.full) begin
                errors++;
                $display("FAIL %s: got paddr=%h fault=%b err=%b full=%b want paddr=%h fault=%b err=%b full=%b",
                         e.name, o.paddr, o.fault, o.err, o.full, e.paddr, e.fault, e.err, e.full);
            end
        end
    endtask

    task automatic test_async_reset();
        res_t e, o;
        @(negedge clk);
        tlb_we    = 1'b1;
        tlb_vpage = 20'h00900;
        tlb_ppage = 20'h00999;
        #1 clrn = 1'b0;
        #1;
        probe_exp("async_rst_passthru", 32'h0030_0123, 1'b1, 32'h0030_0123, 2'b00, 1'b0);
        @(negedge clk);
        tlb_we     = 1'b0;
        clrn       = 1'b1;
        mmu_update = 1'b1;
        mmu_en     = 1'b1;
        probe_exp("rst_cleared_miss", 32'h0030_0123, 1'b0, 32'h0030_0123, 2'b01, 1'b0);
        probe_exp("rst_dropped_write", 32'h0090_0123, 1'b0, 32'h0090_0123, 2'b01, 1'b0);
        @(negedge clk);
        mmu_update = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.paddr !== e.paddr || o.fault !== e.fault || o.err !== e.err || o.full !== e.full) begin
                errors++;
                $display("FAIL %s: got paddr=%h fault=%b err=%b full=%b want paddr=%h fault=%b err=%b full=%b",
                         e.name, o.paddr, o.fault, o.err, o.full, e.paddr, e.fault, e.err, e.full);
            end
        end
    endtask

`ifdef TLB_ASID_EN
    task automatic test_asid();
        res_t e, o;
        @(negedge clk);
        tlb_flush = 1'b1;
        @(negedge clk);
        tlb_flush  = 1'b0;
        mmu_update = 1'b1;
        mmu_en     = 1'b1;
        asid_in    = 6'd3;
        tlb_we     = 1'b1;
        tlb_vpage  = 20'h00400;
        tlb_ppage  = 20'h80010;
        @(negedge clk);
        mmu_update = 1'b0;
        tlb_we     = 1'b0;
        asid_in    = 6'd0;
        probe_exp("asid3_hit", 32'h0040_0000, 1'b0, 32'h8001_0000, 2'b00, 1'b0);
        @(negedge clk);
        mmu_update = 1'b1;
        asid_in    = 6'd5;
        probe_exp("asid5_bypass_miss", 32'h0040_0000, 1'b0, 32'h0040_0000, 2'b01, 1'b0);
        @(negedge clk);
        mmu_update = 1'b0;
        asid_in    = 6'd0;
        probe_exp("asid5_miss", 32'h0040_0000, 1'b0, 32'h0040_0000, 2'b01, 1'b0);
        @(negedge clk);
        mmu_update = 1'b1;
        asid_in    = 6'd3;
        @(negedge clk);
        mmu_update = 1'b0;
        asid_in    = 6'd0;
        probe_exp("asid3_again_hit", 32'h0040_0000, 1'b0, 32'h8001_0000, 2'b00, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.paddr !== e.paddr || o.fault !== e.fault || o.err !== e.err || o.full !== e.full) begin
                errors++;
                $display("FAIL %s: got paddr=%h fault=%b err=%b full=%b want paddr=%h fault=%b err=%b full=%b",
                         e.name, o.paddr, o.fault, o.err, o.full, e.paddr, e.fault, e.err, e.full);
            end
        end
    endtask
`endif

    initial begin
        clrn       = 1'b0;
        stall      = 1'b0;
        mmu_en     = 1'b0;
        mmu_update = 1'b0;
        vaddr_in   = 32'h0;
        wr_in      = 1'b0;
        tlb_we     = 1'b0;
        tlb_vpage  = 20'h0;
        tlb_ppage  = 20'h0;
        tlb_ro     = 1'b0;
        tlb_flush  = 1'b0;
`ifdef TLB_ASID_EN
        asid_in    = 6'd0;
`endif
        test_reset();
        test_translate();
        test_write_protect();
        test_fill_replace();
        test_flush_stall();
        test_back_to_back();
        test_async_reset();
`ifdef TLB_ASID_EN
        test_asid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_mmu.md
# tlb_mmu

Multi-entry successor to the single-page memory management unit. It translates 32-bit virtual addresses through a fully associative, parametrised translation buffer of ENTRIES page mappings. It adds per-entry valid and read-only bits, round-robin replacement, flush, and encoded fault reporting. It sits between the CU/address path and memory, with the same combinational translate path as its predecessor.

## Interface
- PAGE_NUM_WIDTH, 20, page-number width; the offset is 32-PAGE_NUM_WIDTH bits.
- ENTRIES, 8, number of mappings; must be a power of two and at least 2.
- ASID_WIDTH, 6, address-space ID width; used only with TLB_ASID_EN.

- clk  in  1  clock; rising edge.
- clrn  in  1  reset; asynchronous, active-low.
- stall  in  1  pipeline stall; when high, all state updates are blocked.
- mmu_en  in  1  requested mode: 1 = user (translate), 0 = kernel (pass-through).
- mmu_update  in  1  valid eret; latches mmu_en (and asid_in when TLB_ASID_EN).
- vaddr_in  in  32  virtual address of the current access.
- wr_in  in  1  the current access is a store.
- tlb_we  in  1  write one mapping.
- tlb_vpage, tlb_ppage  in  PAGE_NUM_WIDTH  mapping to write.
- tlb_ro  in  1  read-only flag of the mapping being written.
- tlb_flush  in  1  invalidate all entries.
- asid_in  in  ASID_WIDTH  current ASID; port present only with TLB_ASID_EN.
- paddr_o  out  32  physical address.
- fault_o  out  2  fault code: 00 none, 01 miss, 10 write-protect.
- mmu_error_o  out  1  OR of fault_o.
- full_o  out  1  all entries valid.

## Operation
- Effective mode: en = mmu_update ? mmu_en : en_reg.
  - When TLB_ASID_EN is defined, the effective ASID is selected the same way (asid_in bypasses asid_reg during mmu_update).
- Translation when en=0:
  - paddr_o = vaddr_in.
  - fault_o = 00.
- Translation when en=1:
  - The tag is vaddr_in[31:32-PAGE_NUM_WIDTH]. An entry hits when it is valid and its vpage equals the tag.
  - On a hit: paddr_o = {ppage, offset}.
    - If the entry is read-only and wr_in=1, fault_o = 10.
    - Otherwise fault_o = 00.
  - On a miss: fault_o = 01 and paddr_o = vaddr_in.
  - Duplicate hits cannot occur, because the write rule below prevents them.
- Write rule, applied on a clock edge when tlb_we=1 and stall=0. The first matching case below applies:
  1. A valid entry with vpage == tlb_vpage (and the same ASID when TLB_ASID_EN) exists: overwrite that entry's ppage and ro.
  2. Some entry is invalid: fill the lowest-index invalid entry.
  3. Otherwise (buffer full): write the entry at rr_ptr, then rr_ptr <= rr_ptr+1, wrapping modulo ENTRIES.
  - rr_ptr changes only in case 3.
- Flush, applied when tlb_flush=1 and stall=0:
  - All valid bits clear on the next edge; rr_ptr resets to 0.
  - A simultaneous tlb_we is dropped; flush has priority.
- Mode latch: when mmu_update=1 and stall=0, en_reg <= mmu_en.
  - This is independent of, and may coincide with, a write or a flush.
- full_o is the AND of all valid bits.

## Timing
- Translation and fault outputs are purely combinational on the current inputs and state, with zero latency.
- A write or flush becomes visible to lookups one cycle after the capturing edge. A same-cycle lookup uses the old contents; there is no write bypass.
- Reset (clrn low, at any time including mid-write or mid-flush):
  - All valid bits, ro bits, en_reg, rr_ptr and asid_reg clear immediately.
  - Consequences: paddr_o = vaddr_in, fault_o = 00, mmu_error_o = 0, full_o = 0.
  - vpage/ppage storage is not reset.
- With stall high, no register changes; the outputs still track their inputs combinationally.

## Configuration
- TLB_ASID_EN defined:
  - Each entry stores an ASID, taken from the effective ASID at write time.
  - A hit additionally requires entry ASID == effective ASID.
  - The write-rule match (case 1) also compares ASID.
  - The asid_in port exists.
- TLB_ASID_EN undefined:
  - No ASID storage, no asid_in port, and no ASID term in any comparison.

## Structure
- Shared package mmu_pkg holds:
  - Fault code constants: FAULT_NONE = 2'b00, FAULT_MISS = 2'b01, FAULT_WP = 2'b10.
  - The entry record typedef: valid, ro, vpage, ppage, optional asid.
- One sub-module, tlb_match: a per-entry comparator producing the hit bit, instantiated ENTRIES times.
- Hit one-hot to index encoding, lowest-invalid priority encoding and the rr_ptr logic stay in tlb_mmu.

## Test plan
- Reset, then mmu_en=0 and vaddr_in=0x1234_5678 -> paddr_o=0x1234_5678, fault_o=00, full_o=0.
- mmu_update with mmu_en=1, write vpage 0x00400 -> ppage 0x80010 (ro=0), then on the next cycle load vaddr_in=0x0040_0ABC -> paddr_o=0x8001_0ABC, fault_o=00. The same access in the write cycle itself -> fault_o=01.
- Write vpage 0x00401 with ro=1, then store (wr_in=1) to 0x0040_1000 -> fault_o=10, mmu_error_o=1. A load to the same address -> fault_o=00.
- Write 9 distinct vpages with ENTRIES=8:
  - full_o rises after the 8th write.
  - The 9th write replaces entry 0, so the old vpage in entry 0 now misses (01); rr_ptr=1.
  - Rewriting an existing vpage changes only its ppage; rr_ptr is unchanged.
- Assert tlb_flush and tlb_we together -> next cycle all lookups miss, full_o=0, and the written mapping is absent. Repeat with stall=1 -> contents are unchanged.
- TLB_ASID_EN: write vpage 0x00400 under ASID 3, then eret to ASID 5 -> lookup of 0x0040_0000 gives fault_o=01. eret back to ASID 3 -> hit.
